inst_fetch_unit: RTL

Fetch stage directly upstream of the instruction memory. It holds the program counter and drives the memory's word address and read-enable. It captures each returned instruction word together with its PC into a 2-entry queue. The queue feeds decode over a valid/ready handshake and supports branch redirects and address faults.

---
 rtl/inst_fetch_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and buffers
// {inst, pc} pairs in a 2-entry queue that feeds decode.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    input  logic [31:0] mem_out,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic        dbg_state
);

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} fsm_e;

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    fsm_e        fsm_q, fsm_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] head_inst_q, head_inst_d, head_pc_q, head_pc_d;
    logic [31:0] tail_inst_q, tail_inst_d, tail_pc_q, tail_pc_d;
    logic [1:0]  count_q, count_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic        pop, fetch, seq_oob, redir_bad;
    logic [31:0] pc_next;

    // Handshake: a head entry moves to decode exactly when dec_valid and dec_ready
    // are both high at a rising edge; dec_valid never depends on dec_ready.
    assign pop       = (count_q != 2'd0) && dec_ready;
    assign fetch     = (fsm_q == ST_RUN) && !redirect && !rst && ((count_q != 2'd2) || pop);
    assign pc_next   = pc_q + 32'd4;
    assign seq_oob   = {2'b00, pc_next[31:2]} >= MEM_WORDS_W;
    assign redir_bad = (redirect_pc[1:0] != 2'b00) || ({2'b00, redirect_pc[31:2]} >= MEM_WORDS_W);

    always_comb begin
        fsm_d       = fsm_q;
        pc_d        = pc_q;
        head_inst_d = head_inst_q;
        head_pc_d   = head_pc_q;
        tail_inst_d = tail_inst_q;
        tail_pc_d   = tail_pc_q;
        count_d     = count_q;
        fault_d     = fault_q;
        fault_pc_d  = fault_pc_q;

        if (redirect) begin
            count_d = 2'd0;
            if (redir_bad) begin
                fsm_d      = ST_HALT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end else begin
                fsm_d   = ST_RUN;
                pc_d    = redirect_pc;
                fault_d = 1'b0;
            end
        end else begin
            case ({fetch, pop})
                2'b11: begin
                    // A full queue shifts the tail forward; otherwise the new word becomes head.
                    if (count_q == 2'd2) begin
                        head_inst_d = tail_inst_q;
                        head_pc_d   = tail_pc_q;
                        tail_inst_d = mem_out;
                        tail_pc_d   = pc_q;
                    end else begin
                        head_inst_d = mem_out;
                        head_pc_d   = pc_q;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_inst_d = mem_out;
                        head_pc_d   = pc_q;
                    end else begin
                        tail_inst_d = mem_out;
                        tail_pc_d   = pc_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_inst_d = tail_inst_q;
                        head_pc_d   = tail_pc_q;
                    end
                    count_d = count_q - 2'd1;
                end
                default: ;
            endcase
            if (fetch) begin
                pc_d = pc_next;
                if (seq_oob) begin
                    fsm_d      = ST_HALT;
                    fault_d    = 1'b1;
                    fault_pc_d = pc_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_RUN;
            pc_q        <= RESET_PC;
            head_inst_q <= 32'h0;
            head_pc_q   <= 32'h0;
            tail_inst_q <= 32'h0;
            tail_pc_q   <= 32'h0;
            count_q     <= 2'd0;
            fault_q     <= 1'b0;
            fault_pc_q  <= 32'h0;
        end else begin
            fsm_q       <= fsm_d;
            pc_q        <= pc_d;
            head_inst_q <= head_inst_d;
            head_pc_q   <= head_pc_d;
            tail_inst_q <= tail_inst_d;
            tail_pc_q   <= tail_pc_d;
            count_q     <= count_d;
            fault_q     <= fault_d;
            fault_pc_q  <= fault_pc_d;
        end
    end

    assign mem_addr  = {2'b00, pc_q[31:2]};
    assign mem_re    = fetch;
    assign dec_valid = (count_q != 2'd0);
    assign dec_inst  = head_inst_q;
    assign dec_pc    = head_pc_q;
    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;
    assign dbg_state = fsm_q;

endmodule
